// File: rtl/memory_stage.sv
// Y86-64 pipeline memory stage: 1 KiB byte-addressed data memory with
// 8-byte little-endian accesses, plus the W pipeline register.
module memory_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  M_stat,
   input  logic [3:0]  M_icode,
   input  logic        M_Cnd,
   input  logic [63:0] M_valE,
   input  logic [63:0] M_valA,
   input  logic [3:0]  M_dstE,
   input  logic [3:0]  M_dstM,
   input  logic        W_stall,
   input  logic        W_bubble,
   input  logic        ld_en,
   input  logic [9:0]  ld_addr,
   input  logic [7:0]  ld_data,
   output logic [63:0] m_valM,
   output logic [1:0]  m_stat,
   output logic [1:0]  W_stat,
   output logic [3:0]  W_icode,
   output logic [63:0] W_valE,
   output logic [63:0] W_valM,
   output logic [3:0]  W_dstE,
   output logic [3:0]  W_dstM
);

   localparam logic [1:0] STAT_AOK = 2'b00;
   localparam logic [1:0] STAT_ADR = 2'b10;

   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] REG_NONE = 4'hF;

   // Highest start address whose 8-byte window still fits in 1024 bytes.
   localparam logic [63:0] MAX_ADDR = 64'd1016;

   logic [7:0]  mem [0:1023];

   logic        mem_read;
   logic        mem_write;
   logic [63:0] acc_addr;
   logic        dmem_error;
   logic        write_commit;
   logic [63:0] rd_data;

   // M_Cnd only matters to later stages; it is not used for memory access here.
   logic        cnd_unused;
   assign cnd_unused = M_Cnd;

   // Decode access kind and address from the icode, then range-check it.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      acc_addr  = M_valE;
      case (M_icode)
         I_MRMOVQ:                   mem_read  = 1'b1;
         I_RET, I_POPQ: begin
            mem_read = 1'b1;
            acc_addr = M_valA;
         end
         I_RMMOVQ, I_CALL, I_PUSHQ:  mem_write = 1'b1;
         default: begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end
      endcase
      dmem_error   = (mem_read || mem_write) && (acc_addr > MAX_ADDR);
      // Writes are held off when this or the W instruction has faulted so
      // that an exception leaves memory in its pre-fault state.
      write_commit = mem_write && !dmem_error && (M_stat == STAT_AOK) &&
                     (W_stat == STAT_AOK) && !rst;
   end

   // Assemble the little-endian 8-byte read window; 10-bit index wraps
   // harmlessly because out-of-range results are masked below.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < 8; i++) begin
         rd_data[8*i +: 8] = mem[acc_addr[9:0] + 10'(i)];
      end
      m_valM = (mem_read && !dmem_error) ? rd_data : 64'd0;
      m_stat = dmem_error ? STAT_ADR : M_stat;
   end

   // Memory array: pipeline writes take priority over the test preload port;
   // neither is allowed while reset is asserted, and reset never clears it.
   always_ff @(posedge clk) begin
      if (write_commit) begin
         for (int i = 0; i < 8; i++) begin
            mem[acc_addr[9:0] + 10'(i)] <= M_valA[8*i +: 8];
         end
      end else if (ld_en && !rst) begin
         mem[ld_addr] <= ld_data;
      end
   end

   // W pipeline register: reset and bubble insert a nop, stall holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         W_stat  <= STAT_AOK;
         W_icode <= I_NOP;
         W_valE  <= 64'd0;
         W_valM  <= 64'd0;
         W_dstE  <= REG_NONE;
         W_dstM  <= REG_NONE;
      end else if (W_stall) begin
         W_stat  <= W_stat;
         W_icode <= W_icode;
         W_valE  <= W_valE;
         W_valM  <= W_valM;
         W_dstE  <= W_dstE;
         W_dstM  <= W_dstM;
      end else if (W_bubble) begin
         W_stat  <= STAT_AOK;
         W_icode <= I_NOP;
         W_valE  <= 64'd0;
         W_valM  <= 64'd0;
         W_dstE  <= REG_NONE;
         W_dstM  <= REG_NONE;
      end else begin
         W_stat  <= m_stat;
         W_icode <= M_icode;
         W_valE  <= M_valE;
         W_valM  <= m_valM;
         W_dstE  <= M_dstE;
         W_dstM  <= M_dstM;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Directed testbench for memory_stage with hand-computed expected values.
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  M_stat;
   logic [3:0]  M_icode;
   logic        M_Cnd;
   logic [63:0] M_valE, M_valA;
   logic [3:0]  M_dstE, M_dstM;
   logic        W_stall, W_bubble;
   logic        ld_en;
   logic [9:0]  ld_addr;
   logic [7:0]  ld_data;
   logic [63:0] m_valM;
   logic [1:0]  m_stat;
   logic [1:0]  W_stat;
   logic [3:0]  W_icode;
   logic [63:0] W_valE, W_valM;
   logic [3:0]  W_dstE, W_dstM;

   int checks = 0;
   int errors = 0;

   memory_stage dut (
      .clk(clk), .rst(rst),
      .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
      .M_valE(M_valE), .M_valA(M_valA),
      .M_dstE(M_dstE), .M_dstM(M_dstM),
      .W_stall(W_stall), .W_bubble(W_bubble),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .m_valM(m_valM), .m_stat(m_stat),
      .W_stat(W_stat), .W_icode(W_icode),
      .W_valE(W_valE), .W_valM(W_valM),
      .W_dstE(W_dstE), .W_dstM(W_dstM)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one posedge, then settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input logic [1:0] stat, input logic [3:0] icode,
                        input logic [63:0] vale, input logic [63:0] vala,
                        input logic [3:0] dste, input logic [3:0] dstm);
      M_stat  = stat;
      M_icode = icode;
      M_valE  = vale;
      M_valA  = vala;
      M_dstE  = dste;
      M_dstM  = dstm;
   endtask

   initial begin
      rst = 1'b1; M_Cnd = 1'b0;
      W_stall = 1'b0; W_bubble = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      set_m(2'b00, 4'h1, 64'd0, 64'd0, 4'hf, 4'hf);
      #2;
      // Reset state
      check("rst_W_stat",  64'(W_stat),  64'h0);
      check("rst_W_icode", 64'(W_icode), 64'h1);
      check("rst_W_valM",  W_valM,       64'h0);
      check("rst_W_dstE",  64'(W_dstE),  64'hf);
      check("rst_W_dstM",  64'(W_dstM),  64'hf);
      tick();
      rst = 1'b0;

      // Preload 0x10..0x17 with 0x11..0x88
      for (int i = 0; i < 8; i++) begin
         ld_en   = 1'b1;
         ld_addr = 10'(16 + i);
         ld_data = 8'(8'h11 * (i + 1));
         tick();
      end
      ld_en = 1'b0;

      // Read of preloaded data
      set_m(2'b00, 4'h5, 64'h10, 64'h0, 4'h3, 4'h4);
      #1;
      check("rd_m_valM", m_valM, 64'h8877665544332211);
      check("rd_m_stat", 64'(m_stat), 64'h0);
      tick();
      check("rd_W_valM",  W_valM,       64'h8877665544332211);
      check("rd_W_stat",  64'(W_stat),  64'h0);
      check("rd_W_icode", 64'(W_icode), 64'h5);
      check("rd_W_valE",  W_valE,       64'h10);
      check("rd_W_dstE",  64'(W_dstE),  64'h3);
      check("rd_W_dstM",  64'(W_dstM),  64'h4);

      // Push at the highest legal address, then pop it back next cycle
      set_m(2'b00, 4'hA, 64'h3F8, 64'hDEADBEEF, 4'h4, 4'hf);
      #1;
      check("push_m_stat", 64'(m_stat), 64'h0);
      check("push_m_valM", m_valM, 64'h0);
      tick();
      set_m(2'b00, 4'hB, 64'h400, 64'h3F8, 4'h4, 4'h0);
      #1;
      check("pop_m_valM", m_valM, 64'hDEADBEEF);
      check("pop_m_stat", 64'(m_stat), 64'h0);
      tick();

      // Out-of-range writes: just past the end, and a huge unsigned address
      set_m(2'b00, 4'h4, 64'h3F9, 64'h1122334455667788, 4'hf, 4'hf);
      #1;
      check("adr1_m_stat", 64'(m_stat), 64'h2);
      tick();
      check("adr1_W_stat", 64'(W_stat), 64'h2);
      set_m(2'b00, 4'h4, 64'hFFFFFFFFFFFFFFF8, 64'h1122334455667788, 4'hf, 4'hf);
      #1;
      check("adr2_m_stat", 64'(m_stat), 64'h2);
      tick();
      check("adr2_W_stat", 64'(W_stat), 64'h2);
      // Out-of-range read returns zero with ADR status
      set_m(2'b00, 4'h5, 64'h3F9, 64'h0, 4'hf, 4'h2);
      #1;
      check("adr_rd_m_valM", m_valM, 64'h0);
      check("adr_rd_m_stat", 64'(m_stat), 64'h2);
      // Memory at 0x3F8 unchanged by the faulting writes
      set_m(2'b00, 4'hB, 64'h0, 64'h3F8, 4'h4, 4'h0);
      #1;
      check("adr_mem_kept", m_valM, 64'hDEADBEEF);
      tick();
      check("pop2_W_stat", 64'(W_stat), 64'h0);
      check("pop2_W_valM", W_valM, 64'hDEADBEEF);

      // Stall beats bubble
      W_stall = 1'b1; W_bubble = 1'b1;
      set_m(2'b00, 4'h5, 64'h10, 64'h0, 4'h3, 4'h4);
      tick();
      check("stall_W_icode", 64'(W_icode), 64'hB);
      check("stall_W_valM",  W_valM,       64'hDEADBEEF);
      check("stall_W_dstM",  64'(W_dstM),  64'h0);
      W_stall = 1'b0;
      tick();
      check("bub_W_icode", 64'(W_icode), 64'h1);
      check("bub_W_dstE",  64'(W_dstE),  64'hf);
      check("bub_W_dstM",  64'(W_dstM),  64'hf);
      check("bub_W_valM",  W_valM,       64'h0);
      W_bubble = 1'b0;

      // HLT status blocks a write
      set_m(2'b01, 4'h8, 64'h10, 64'hAAAAAAAAAAAAAAAA, 4'h4, 4'hf);
      #1;
      check("hlt_m_stat", 64'(m_stat), 64'h1);
      tick();
      check("hlt_W_stat", 64'(W_stat), 64'h1);
      set_m(2'b00, 4'h5, 64'h10, 64'h0, 4'hf, 4'h1);
      #1;
      check("hlt_mem_kept", m_valM, 64'h8877665544332211);
      tick();

      // Asynchronous reset mid-cycle while a write is pending
      set_m(2'b00, 4'h4, 64'h10, 64'h5555555555555555, 4'hf, 4'hf);
      #2;
      rst = 1'b1;
      #1;
      check("arst_W_icode", 64'(W_icode), 64'h1);
      check("arst_W_valM",  W_valM,       64'h0);
      check("arst_W_dstM",  64'(W_dstM),  64'hf);
      tick();
      set_m(2'b00, 4'h5, 64'h10, 64'h0, 4'h2, 4'h6);
      #1;
      check("arst_mem_kept", m_valM, 64'h8877665544332211);
      rst = 1'b0;
      tick();
      check("post_rst_W_icode", 64'(W_icode), 64'h5);
      check("post_rst_W_valM",  W_valM,       64'h8877665544332211);

      // Pipeline write and preload in the same cycle: preload is dropped
      set_m(2'b00, 4'hA, 64'h20, 64'h0102030405060708, 4'h4, 4'hf);
      ld_en = 1'b1; ld_addr = 10'h20; ld_data = 8'hFF;
      tick();
      ld_en = 1'b0;
      set_m(2'b00, 4'h5, 64'h20, 64'h0, 4'hf, 4'h1);
      #1;
      check("ld_drop", m_valM, 64'h0102030405060708);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 M_stat  in  2  status in M register; 00 AOK, 01 HLT, 10 ADR, 11 INS.
REQ-004 M_icode  in  4  Y86-64 icode in M register.
REQ-005 M_Cnd  in  1  condition flag from execute; passed through, not used for memory access.
REQ-006 M_valE, M_valA  in  64 each  ALU result and source-A value.
REQ-007 M_dstE, M_dstM  in  4 each  destination registers; 4'hf means none.
REQ-008 W_stall, W_bubble  in  1 each  pipeline control for the W register.
REQ-009 ld_en  in  1  test preload strobe.
REQ-010 ld_addr  in  10  test preload byte address.
REQ-011 ld_data  in  8  test preload byte value.
REQ-012 m_valM  out  64  combinational read data.
REQ-013 m_stat  out  2  combinational stage status, forwarded to control logic.
REQ-014 W_stat  out  2  registered W-stage status.
REQ-015 W_icode  out  4  registered W-stage icode.
REQ-016 W_valE, W_valM  out  64 each  registered W-stage data values.
REQ-017 W_dstE, W_dstM  out  4 each  registered W-stage destination registers.

Function
REQ-018 Data memory SHALL be 1024 bytes, byte-addressed, with 8-byte little-endian accesses; unaligned addresses are legal.
REQ-019 Access address SHALL be M_valE for icodes 4, 5, 8 and A, and M_valA for icodes 9 and B; no access occurs for any other icode.
REQ-020 A read SHALL occur for icodes 5, 9 and B; a write SHALL occur for icodes 4, 8 and A, with write data M_valA.
REQ-021 dmem_error SHALL assert when an access occurs and the 64-bit address, taken as unsigned, is greater than 1016.
REQ-022 m_valM SHALL equal the 8 bytes at the access address when a read occurs without error, and 0 otherwise.
REQ-023 m_stat SHALL be ADR when dmem_error is asserted, and M_stat otherwise.
REQ-024 The write SHALL commit at posedge only if dmem_error=0, M_stat=AOK and W_stat=AOK; otherwise memory is unchanged.
REQ-025 While rst is low, ld_en=1 SHALL write ld_data to byte ld_addr at posedge, unless a pipeline write commits in the same cycle, in which case the ld write is dropped.
REQ-026 At posedge with W_stall=1, all W_* outputs SHALL hold their values; stall has priority over bubble.
REQ-027 At posedge with W_bubble=1 and W_stall=0, W_* SHALL load the bubble values: stat 00, icode 1, valE 0, valM 0, dstE f, dstM f.
REQ-028 At posedge otherwise, W_* SHALL load: stat=m_stat, icode=M_icode, valE=M_valE, valM=m_valM, dstE=M_dstE, dstM=M_dstM.
REQ-029 Latency SHALL be 0 cycles for m_valM and m_stat, and 1 cycle into W_*.
REQ-030 A read and a write to overlapping bytes never occur in the same cycle, because each icode does either a read or a write.
REQ-031 A write followed by a read of the same address in the next cycle SHALL return the new data.

Reset
REQ-032 rst=1 SHALL immediately force all W_* outputs to the bubble values, independent of clk.
REQ-033 Memory contents SHALL NOT be altered by reset; pipeline writes and ld writes are suppressed while rst=1.
REQ-034 After rst is released, the first posedge SHALL perform a normal update per REQ-026 to REQ-028.

Verification
REQ-035 Preload bytes 0x10 to 0x17 with 0x11 to 0x88; then M_icode=5, M_valE=0x10 -> m_valM=0x8877665544332211; next cycle W_valM equals that value and W_stat=00.
REQ-036 M_icode=A, M_valE=0x3F8, M_valA=0xDEADBEEF; next cycle M_icode=B, M_valA=0x3F8 -> m_valM=0xDEADBEEF.
REQ-037 M_icode=4, M_valE=0x3F9 -> m_stat=10, memory unchanged, next W_stat=10; repeat with M_valE=0xFFFFFFFFFFFFFFF8 -> same result.
REQ-038 W_stall=1 and W_bubble=1 with new M inputs -> W_* unchanged; then W_bubble=1 alone -> W_icode=1, W_dstE=f, W_dstM=f.
REQ-039 rst pulsed mid-cycle while M_icode=4 is valid -> W_* at bubble values immediately, target bytes unchanged after the following posedge.
REQ-040 M_stat=01 with M_icode=8 and a valid address -> no write, m_stat=01, and W_stat=01 at the next posedge.
